// File: rtl/rv_wb_sched_pkg.sv
// Shared types and defaults for the write-back scheduler: LLU result record,
// sizing defaults and the write-port source select.
package rv_wb_sched_pkg;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } t_llu_res;

  localparam int LLU_MAX_OUT_DEF = 4;
  localparam int STARVE_MAX_DEF  = 8;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_PIPE = 2'd1,
    WB_LLU  = 2'd2
  } t_wb_src;

endpackage

// File: rtl/rv_wb_sched_if.sv
// Decode, Q104H write-back, LLU result and RF write-port signals of the scheduler.
// slave is the scheduler side, master the pipeline/LLU/RF side.
interface rv_wb_sched_if;
  logic [4:0]  rs1_Q101H;
  logic [4:0]  rs2_Q101H;
  logic [4:0]  rd_Q101H;
  logic        llu_issue_Q101H;
  logic        stall_Q101H;
  logic        reg_write_en_Q104H;
  logic [4:0]  rd_Q104H;
  logic [31:0] wb_data_Q104H;
  logic        llu_valid;
  logic [4:0]  llu_rd;
  logic [31:0] llu_data;
  logic        llu_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] pending_mask;

  modport slave (
    input  rs1_Q101H, rs2_Q101H, rd_Q101H, llu_issue_Q101H,
    input  reg_write_en_Q104H, rd_Q104H, wb_data_Q104H,
    input  llu_valid, llu_rd, llu_data,
    output stall_Q101H, llu_ready, rf_we, rf_rd, rf_wdata, pending_mask
  );

  modport master (
    output rs1_Q101H, rs2_Q101H, rd_Q101H, llu_issue_Q101H,
    output reg_write_en_Q104H, rd_Q104H, wb_data_Q104H,
    output llu_valid, llu_rd, llu_data,
    input  stall_Q101H, llu_ready, rf_we, rf_rd, rf_wdata, pending_mask
  );
endinterface

// File: rtl/rv_wb_fifo.sv
// Small FIFO of LLU results; head is registered storage (no fall-through).
// Push while full is accepted only together with a pop.
module rv_wb_fifo
  import rv_wb_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  t_llu_res din,
  output logic     full,
  output logic     empty,
  output t_llu_res head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  t_llu_res        mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload needs no reset: the count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/rv_wb_sched.sv
// Write-back scheduler: main pipe has priority on the RF write port, LLU results
// drain from a 2-entry buffer; a scoreboard of LLU destinations stalls decode.
module rv_wb_sched
  import rv_wb_sched_pkg::*;
#(
  parameter int LLU_MAX_OUT = LLU_MAX_OUT_DEF,
  parameter int STARVE_MAX  = STARVE_MAX_DEF
) (
  input logic         clk,
  input logic         rst,
  rv_wb_sched_if.slave bus
);
  localparam int OW = $clog2(LLU_MAX_OUT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [31:0]   mask_q, mask_d;
  logic [OW-1:0] out_q, out_d;
  logic [SW-1:0] stv_q, stv_d;

  t_llu_res head, din;
  logic     full, empty, push, pop;
  logic     pipe_wr, starve, raw, waw, lim, stall, issue_ok;
  t_wb_src  src;

  assign din.rd   = bus.llu_rd;
  assign din.data = bus.llu_data;

  rv_wb_fifo #(.DEPTH(2)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // Outputs are forced safe while reset is held, independent of the inputs.
  assign pipe_wr  = bus.reg_write_en_Q104H && (bus.rd_Q104H != 5'd0);
  assign pop      = rst && !pipe_wr && !empty;
  assign push     = bus.llu_valid && bus.llu_ready;
  assign src      = pipe_wr ? WB_PIPE : (pop ? WB_LLU : WB_NONE);

  assign bus.llu_ready = rst && !full;

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_rd    = 5'd0;
    bus.rf_wdata = 32'd0;
    case (src)
      WB_PIPE: begin
        bus.rf_we    = rst;
        bus.rf_rd    = bus.rd_Q104H;
        bus.rf_wdata = bus.wb_data_Q104H;
      end
      WB_LLU: begin
        bus.rf_we    = (head.rd != 5'd0);
        bus.rf_rd    = head.rd;
        bus.rf_wdata = head.data;
      end
      default: ;
    endcase
  end

  assign starve   = (stv_q == SW'(STARVE_MAX));
  assign raw      = ((bus.rs1_Q101H != 5'd0) && mask_q[bus.rs1_Q101H]) ||
                    ((bus.rs2_Q101H != 5'd0) && mask_q[bus.rs2_Q101H]);
  assign waw      = (bus.rd_Q101H != 5'd0) && mask_q[bus.rd_Q101H];
  assign lim      = bus.llu_issue_Q101H && (out_q == OW'(LLU_MAX_OUT));
  assign stall    = !rst || raw || waw || lim || starve;
  assign issue_ok = bus.llu_issue_Q101H && !stall;

  assign bus.stall_Q101H  = stall;
  assign bus.pending_mask = mask_q;

  always_comb begin
    mask_d = mask_q;
    if (pop && (head.rd != 5'd0))                mask_d[head.rd] = 1'b0;
    if (issue_ok && (bus.rd_Q101H != 5'd0))      mask_d[bus.rd_Q101H] = 1'b1;

    case ({issue_ok, pop})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase

    if (empty || pop) stv_d = '0;
    else if (!starve) stv_d = stv_q + 1'b1;
    else              stv_d = stv_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q <= '0;
      out_q  <= '0;
      stv_q  <= '0;
    end else begin
      mask_q <= mask_d;
      out_q  <= out_d;
      stv_q  <= stv_d;
    end
  end
endmodule

// File: tb/tb_rv_wb_sched.sv
// Directed bench for rv_wb_sched: issue/write-back, port conflict, starvation,
// limits, x0/WAW and reset mid-operation.
module tb_rv_wb_sched;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  rv_wb_sched_if bus ();

  rv_wb_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idle();
    bus.rs1_Q101H          = 5'd0;
    bus.rs2_Q101H          = 5'd0;
    bus.rd_Q101H           = 5'd0;
    bus.llu_issue_Q101H    = 1'b0;
    bus.reg_write_en_Q104H = 1'b0;
    bus.rd_Q104H           = 5'd0;
    bus.wb_data_Q104H      = 32'd0;
    bus.llu_valid          = 1'b0;
    bus.llu_rd             = 5'd0;
    bus.llu_data           = 32'd0;
  endtask

  // Inputs change 1 time unit after the edge, checks 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.llu_issue_Q101H = 1'b1;
    bus.rd_Q101H        = rd;
    tick();
    bus.llu_issue_Q101H = 1'b0;
    bus.rd_Q101H        = 5'd0;
  endtask

  task automatic pipe(input logic en, input logic [4:0] rd, input logic [31:0] d);
    bus.reg_write_en_Q104H = en;
    bus.rd_Q104H           = rd;
    bus.wb_data_Q104H      = d;
  endtask

  task automatic llu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.llu_valid = v;
    bus.llu_rd    = rd;
    bus.llu_data  = d;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    idle();
    pipe(1'b1, 5'd7, 32'h77);
    #2;
    chk("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall_Q101H}, 32'd1);
    chk("rst_ready", {31'd0, bus.llu_ready}, 32'd0);
    chk("rst_mask", bus.pending_mask, 32'd0);
    tick();
    tick();
    idle();
    rst = 1'b1;
    tick();

    // issue and write-back
    bus.llu_issue_Q101H = 1'b1;
    bus.rd_Q101H        = 5'd5;
    settle();
    chk("t1_issue_ok", {31'd0, bus.stall_Q101H}, 32'd0);
    tick();
    bus.llu_issue_Q101H = 1'b0;
    bus.rd_Q101H        = 5'd0;
    bus.rs1_Q101H       = 5'd5;
    llu(1'b1, 5'd5, 32'hDEAD_BEEF);
    settle();
    chk("t1_raw_stall", {31'd0, bus.stall_Q101H}, 32'd1);
    chk("t1_mask", bus.pending_mask, 32'h20);
    chk("t1_ready", {31'd0, bus.llu_ready}, 32'd1);
    chk("t1_no_fallthru", {31'd0, bus.rf_we}, 32'd0);
    tick();
    llu(1'b0, 5'd0, 32'd0);
    settle();
    chk("t1_rf_we", {31'd0, bus.rf_we}, 32'd1);
    chk("t1_rf_rd", {27'd0, bus.rf_rd}, 32'd5);
    chk("t1_rf_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
    tick();
    settle();
    chk("t1_release", {31'd0, bus.stall_Q101H}, 32'd0);
    chk("t1_mask_clr", bus.pending_mask, 32'd0);
    idle();

    // port conflict
    issue(5'd6);
    pipe(1'b1, 5'd7, 32'h77);
    llu(1'b1, 5'd6, 32'h66);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t2_pipe_rd", {27'd0, bus.rf_rd}, 32'd7);
      chk("t2_ready", {31'd0, bus.llu_ready}, 32'd1);
      tick();
      llu(1'b0, 5'd0, 32'd0);
    end
    pipe(1'b0, 5'd0, 32'd0);
    settle();
    chk("t2_llu_we", {31'd0, bus.rf_we}, 32'd1);
    chk("t2_llu_rd", {27'd0, bus.rf_rd}, 32'd6);
    chk("t2_llu_data", bus.rf_wdata, 32'h66);
    tick();
    chk("t2_mask_clr", bus.pending_mask, 32'd0);

    // starvation
    issue(5'd9);
    pipe(1'b1, 5'd1, 32'h11);
    llu(1'b1, 5'd9, 32'h99);
    tick();
    llu(1'b0, 5'd0, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      settle();
      chk($sformatf("t3_stall_c%0d", i), {31'd0, bus.stall_Q101H}, (i >= 9) ? 32'd1 : 32'd0);
      tick();
    end
    pipe(1'b0, 5'd0, 32'd0);
    settle();
    chk("t3_drain_we", {31'd0, bus.rf_we}, 32'd1);
    chk("t3_drain_rd", {27'd0, bus.rf_rd}, 32'd9);
    tick();
    chk("t3_unstall", {31'd0, bus.stall_Q101H}, 32'd0);
    chk("t3_mask_clr", bus.pending_mask, 32'd0);

    // limits
    issue(5'd10);
    issue(5'd11);
    issue(5'd12);
    issue(5'd13);
    bus.llu_issue_Q101H = 1'b1;
    bus.rd_Q101H        = 5'd14;
    settle();
    chk("t4_max_stall", {31'd0, bus.stall_Q101H}, 32'd1);
    chk("t4_mask", bus.pending_mask, 32'h3C00);
    pipe(1'b1, 5'd1, 32'h11);
    llu(1'b1, 5'd10, 32'hA0);
    tick();
    llu(1'b1, 5'd11, 32'hB0);
    settle();
    chk("t4_ready_one", {31'd0, bus.llu_ready}, 32'd1);
    tick();
    llu(1'b0, 5'd0, 32'd0);
    settle();
    chk("t4_full", {31'd0, bus.llu_ready}, 32'd0);
    pipe(1'b0, 5'd0, 32'd0);
    settle();
    chk("t4_pop_rd", {27'd0, bus.rf_rd}, 32'd10);
    chk("t4_still_stall", {31'd0, bus.stall_Q101H}, 32'd1);
    tick();
    chk("t4_accept", {31'd0, bus.stall_Q101H}, 32'd0);
    chk("t4_ready_back", {31'd0, bus.llu_ready}, 32'd1);
    tick();
    bus.llu_issue_Q101H = 1'b0;
    bus.rd_Q101H        = 5'd0;
    settle();
    chk("t4_mask_after", bus.pending_mask, 32'h7000);
    for (int r = 12; r <= 14; r++) begin
      llu(1'b1, 5'(r), 32'(r));
      tick();
    end
    llu(1'b0, 5'd0, 32'd0);
    tick();
    chk("t4_mask_clr", bus.pending_mask, 32'd0);

    // x0 and WAW
    issue(5'd0);
    chk("t5_x0_mask", bus.pending_mask, 32'd0);
    bus.llu_issue_Q101H = 1'b1;
    bus.rd_Q101H        = 5'd3;
    settle();
    chk("t5_rd3_ok", {31'd0, bus.stall_Q101H}, 32'd0);
    tick();
    settle();
    chk("t5_waw", {31'd0, bus.stall_Q101H}, 32'd1);
    llu(1'b1, 5'd0, 32'hF0);
    tick();
    llu(1'b0, 5'd0, 32'd0);
    settle();
    chk("t5_x0_no_we", {31'd0, bus.rf_we}, 32'd0);
    chk("t5_waw_hold", {31'd0, bus.stall_Q101H}, 32'd1);
    tick();
    llu(1'b1, 5'd3, 32'h33);
    tick();
    llu(1'b0, 5'd0, 32'd0);
    settle();
    chk("t5_rd3_we", {31'd0, bus.rf_we}, 32'd1);
    chk("t5_rd3_rd", {27'd0, bus.rf_rd}, 32'd3);
    tick();
    chk("t5_waw_rel", {31'd0, bus.stall_Q101H}, 32'd0);
    bus.llu_issue_Q101H = 1'b0;
    bus.rd_Q101H        = 5'd0;

    // reset mid-operation
    issue(5'd4);
    issue(5'd5);
    pipe(1'b1, 5'd1, 32'h11);
    llu(1'b1, 5'd4, 32'h44);
    tick();
    llu(1'b1, 5'd5, 32'h55);
    tick();
    llu(1'b0, 5'd0, 32'd0);
    settle();
    chk("t6_mask", bus.pending_mask, 32'h30);
    chk("t6_full", {31'd0, bus.llu_ready}, 32'd0);
    rst = 1'b0;
    settle();
    chk("t6_rst_we", {31'd0, bus.rf_we}, 32'd0);
    chk("t6_rst_stall", {31'd0, bus.stall_Q101H}, 32'd1);
    chk("t6_rst_mask", bus.pending_mask, 32'd0);
    tick();
    rst = 1'b1;
    pipe(1'b0, 5'd0, 32'd0);
    settle();
    chk("t6_ready", {31'd0, bus.llu_ready}, 32'd1);
    chk("t6_no_stale", {31'd0, bus.rf_we}, 32'd0);
    chk("t6_stall_rel", {31'd0, bus.stall_Q101H}, 32'd0);
    tick();
    chk("t6_no_stale2", {31'd0, bus.rf_we}, 32'd0);
    chk("t6_mask0", bus.pending_mask, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/rv_wb_sched.md
# rv_wb_sched

Write-back scheduler for the single register-file write port of `rv_rf`. It merges main-pipe results at Q104H with out-of-order results from a long-latency unit (LLU: mul/div). LLU results are held in a 2-entry buffer until the port is free. A 32-entry scoreboard of LLU-pending destinations stalls decode (Q101H) on RAW/WAW hazards and on write-port starvation.

## Interface
Parameters:
- `LLU_MAX_OUT`, 4: maximum accepted-but-unwritten LLU operations.
- `STARVE_MAX`, 8: cycles a buffered LLU result may wait before decode is stalled.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rs1_Q101H`, `rs2_Q101H`  in  5  decode source registers.
- `rd_Q101H`  in  5  decode destination register.
- `llu_issue_Q101H`  in  1  decode instruction targets the LLU.
- `stall_Q101H`  out  1  hold decode; the instruction is not accepted.
- `reg_write_en_Q104H`, `rd_Q104H`, `wb_data_Q104H`  in  1/5/32  main-pipe write-back.
- `llu_valid`, `llu_rd`, `llu_data`  in  1/5/32  LLU result.
- `llu_ready`  out  1  buffer can accept an LLU result.
- `rf_we`, `rf_rd`, `rf_wdata`  out  1/5/32  drive the `rv_rf` write port (its `*_Q104H` inputs).
- `pending_mask`  out  32  scoreboard, for debug and verification.

## Operation
- **Port arbitration** (combinational):
  - Main pipe owns the port when `reg_write_en_Q104H && rd_Q104H != 0`. Main-pipe writes are never delayed.
  - Otherwise, if the buffer is non-empty, the head is popped and written: `rf_we = (head.rd != 0)`.
  - A head entry with rd=0 is popped with no write.
- **Buffer:**
  - 2-entry FIFO; push on `llu_valid && llu_ready`; `llu_ready = !full`.
  - Push and pop in the same cycle while full is legal; occupancy stays 2.
  - Minimum LLU-to-RF latency is 1 cycle; there is no fall-through.
- **Scoreboard:**
  - Bit r is set on an accepted issue: `llu_issue_Q101H && !stall_Q101H && rd_Q101H != 0`.
  - Bit r is cleared when a popped head with rd=r is written to the RF.
  - A set and a clear of the same bit in one cycle cannot occur, because WAW stalls issue.
- **Outstanding counter:**
  - Increments on every accepted LLU issue, including rd=0.
  - Decrements on every pop.
  - Simultaneous increment and decrement leaves it unchanged.
- **Starvation counter:**
  - Increments each cycle the buffer is non-empty and not popped.
  - Clears on a pop, or when the buffer is empty.
  - Saturates at `STARVE_MAX`; while saturated, `starve = 1`.
- **`stall_Q101H`** is asserted if any of the following holds:
  - `pending_mask[rs1_Q101H]` or `pending_mask[rs2_Q101H]` (RAW), with index 0 ignored;
  - `pending_mask[rd_Q101H]` with `rd_Q101H != 0` (WAW);
  - `llu_issue_Q101H` and the outstanding count equals `LLU_MAX_OUT`;
  - `starve`.
- While starve holds, the main pipe drains within 3 cycles, which frees the port for the buffer.

## Timing
- **Reset (`rst = 0`, asynchronous):**
  - Mask, FIFO pointers, outstanding counter and starve counter all clear to 0.
  - While `rst` is low: `rf_we = 0`, `llu_ready = 0`, `stall_Q101H = 1`, `pending_mask = 0`.
- **Reset mid-operation:** buffered LLU results and pending bits are discarded. The LLU must be reset by the same signal.
- **Combinational outputs:** `stall_Q101H`, `rf_*` and `llu_ready` are combinational from registered state and current inputs. There is no extra pipeline stage.
- **Scoreboard timing:**
  - A bit set at edge N stalls a dependent instruction presented in the cycle after edge N.
  - A bit cleared at edge N releases the stall in the cycle after N; the RF's internal bypass supplies the data.
- **Starvation:** `starve` asserts in the cycle after the counter reaches `STARVE_MAX`.

## Structure
- Shared package `pkg` holds:
  - `t_llu_res` struct `{rd[4:0], data[31:0]}`;
  - `LLU_MAX_OUT_DEF` and `STARVE_MAX_DEF` constants;
  - `t_wb_src` enum `{WB_NONE, WB_PIPE, WB_LLU}`, used for the arbitration select.
- Sub-module `rv_wb_fifo`: a parameterised-depth (2) FIFO of `t_llu_res`, with `push/pop/full/empty/head` and asynchronous active-low reset.
- The scoreboard, counters and arbitration live in `rv_wb_sched`.

## Test plan
- **Issue and write-back:** issue LLU with rd=5 (`llu_issue_Q101H=1`); next cycle present `rs1_Q101H=5`.
  - Expected: `stall_Q101H=1`, `pending_mask=32'h20`.
  - Then `llu_valid`, rd=5, data=`32'hDEAD_BEEF`; one cycle later, with Q104H idle, `rf_we=1`, `rf_rd=5`, `rf_wdata=32'hDEAD_BEEF`.
  - The following cycle: stall drops and the mask is 0.
- **Port conflict:** LLU result (rd=6) pushed while the main pipe writes x7 for 3 consecutive cycles.
  - Expected: `rf_rd=7` for 3 cycles, then `rf_rd=6`; `llu_ready` stays 1.
- **Starvation:** keep `reg_write_en_Q104H=1` (rd=1) continuously with one buffered LLU result.
  - Expected: `stall_Q101H=1` from cycle `STARVE_MAX+1`; once Q104H deasserts, the LLU result is written.
- **Limits:** 4 accepted LLU issues with no results returned; a 5th issue is presented.
  - Expected: `stall_Q101H=1`.
  - After one LLU result is written: issue is accepted.
  - Buffer: 2 pushes with the port blocked give `llu_ready=0`.
- **x0 and WAW:** an LLU issue with rd=0 does not set the mask, and its result pops with `rf_we=0`. An issue with rd=3 while bit 3 is pending gives `stall_Q101H=1`.
- **Reset mid-operation:** drop `rst` low with 2 buffered results and a mask of `32'h30`.
  - Expected: immediately `rf_we=0`, `stall_Q101H=1`, mask 0.
  - After release: `llu_ready=1` and no stale writes.
